region_scan_ctrl: RTL
=====================

REGION_SCAN_CTRL -- requirements
Module: region_scan_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 640, frame width in pixels.
REQ-002 SHALL have parameter HEIGHT, default 480, frame height in lines.
REQ-003 SHALL have parameter STABLE_ROUNDS, default 3, consecutive identical rounds needed to commit a selection (range 1..15).
REQ-004 SHALL have port clk, input, 1, single clock; all logic on posedge.
REQ-005 SHALL have port reset, input, 1, synchronous, active-high.
REQ-006 SHALL have ports x and y, input, 10 each, current pixel coordinates from the VGA timing.
REQ-007 SHALL have port regiao_detectada, input, 1, detection flag from the shared tracker.
REQ-008 SHALL have port region, output, 2, region under scan (0 red, 1 green, 2 yellow, 3 blue).
REQ-009 SHALL have ports reg_min and reg_max, output, 10 each, exclusive x bounds for the tracker.
REQ-010 SHALL have port detect_mask, output, 4, per-region result of the last completed round.
REQ-011 SHALL have ports sel_region (output, 2) and sel_valid (output, 1), the committed selection.
REQ-012 SHALL have port sel_pulse, output, 1, one-cycle strobe when a new selection commits.

Function
REQ-013 SHALL time-multiplex one tracker: one region per frame, order 0,1,2,3, wrapping 3->0.
REQ-014 SHALL drive reg_min = region*(WIDTH/4) and reg_max = (region+1)*(WIDTH/4), registered; region 3 gives reg_max = 640.
REQ-015 SHALL use FSM states IDLE, SCAN, LATCH, EVAL.
REQ-016 IDLE -> SCAN on the cycle x==0 && y==0; region is not advanced.
REQ-017 SCAN -> LATCH on the cycle x==WIDTH-1 && y==HEIGHT-1.
REQ-018 LATCH SHALL last exactly one cycle; it samples regiao_detectada into scratch bit [region].
REQ-019 LATCH -> EVAL if region==3, else -> IDLE with region incremented.
REQ-020 EVAL SHALL last one cycle: copy scratch to detect_mask, clear scratch, set region to 0, go to IDLE.
REQ-021 In EVAL, candidate is valid iff exactly one bit of scratch is set (see REQ-029); candidate = index of that bit.
REQ-022 Valid candidate equal to the previous round's candidate SHALL increment a 4-bit stability counter, saturating at 15; otherwise the counter SHALL be loaded with 1.
REQ-023 No valid candidate SHALL clear the counter, clear sel_valid, and leave sel_region unchanged.
REQ-024 When the counter reaches STABLE_ROUNDS, the block SHALL set sel_valid=1 and sel_region=candidate, and SHALL assert sel_pulse for one cycle (the cycle after EVAL), but only if sel_valid was 0 or sel_region differs.
REQ-025 A frame start seen while in SCAN (truncated frame) SHALL restart the current region's scan and SHALL NOT latch.
REQ-026 EVAL SHALL take priority over any coincident frame start; that frame is skipped and picked up in IDLE on the next frame start.

Reset
REQ-027 On reset, the block SHALL set: state=IDLE, region=0, reg_min=0, reg_max=WIDTH/4, scratch=0, detect_mask=0, counter=0, sel_region=0, sel_valid=0, sel_pulse=0.
REQ-028 Reset asserted mid-round SHALL discard partial results; no sel_pulse SHALL be emitted.

Configuration
REQ-029 Macro REGION_PRIORITY_EN: when defined, multiple set bits give a valid candidate equal to the lowest set index; when undefined, multiple set bits count as no valid candidate.

Verification
REQ-030 Reset, 4 frames with regiao_detectada=1 only during region-1 LATCH -> detect_mask=4'b0010 after the first round; sel_pulse once at round 3 with sel_region=1.
REQ-031 Bounds check: region 2 -> reg_min=320, reg_max=480; region 3 -> reg_min=480, reg_max=640.
REQ-032 Rounds producing masks 0010, 0010, 0000, 0010 -> no commit; counter back to 1 after round 4.
REQ-033 Mask 0110 for 3 rounds -> with REGION_PRIORITY_EN, sel_region=1 committed; without it, sel_valid stays 0.
REQ-034 Stable region 1 committed, then 3 rounds of 1000 -> sel_valid drops on first 1000 round, then sel_pulse with sel_region=3 at round 3.
REQ-035 Reset asserted during region-2 SCAN -> all outputs at reset values next cycle; next frame scans region 0.

Source files
------------

// File: rtl/region_scan_ctrl.sv
// Time-multiplexes one shared tracker across four vertical screen bands and commits
// a stable single-region selection. Optional macro REGION_PRIORITY_EN: lowest set bit wins.
module region_scan_ctrl #(
  parameter int unsigned WIDTH         = 640,
  parameter int unsigned HEIGHT        = 480,
  parameter int unsigned STABLE_ROUNDS = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] x,
  input  logic [9:0] y,
  input  logic       regiao_detectada,
  output logic [1:0] region,
  output logic [9:0] reg_min,
  output logic [9:0] reg_max,
  output logic [3:0] detect_mask,
  output logic [1:0] sel_region,
  output logic       sel_valid,
  output logic       sel_pulse
);

  localparam int unsigned QUARTER = WIDTH / 4;
  localparam logic [9:0]  X_LAST  = 10'(WIDTH - 1);
  localparam logic [9:0]  Y_LAST  = 10'(HEIGHT - 1);
  localparam logic [3:0]  STABLE  = 4'(STABLE_ROUNDS);

  typedef enum logic [1:0] {IDLE, SCAN, LATCH, EVAL} state_t;

  state_t     state, state_n;
  logic [1:0] region_n;
  logic [9:0] reg_min_n, reg_max_n;
  logic [3:0] scratch, scratch_n;
  logic [3:0] detect_mask_n;
  logic [3:0] stab_cnt, stab_cnt_n;
  logic [1:0] prev_cand, prev_cand_n;
  logic [1:0] sel_region_n;
  logic       sel_valid_n, sel_pulse_n;

  logic       frame_start, frame_end;
  logic       cand_valid;
  logic [1:0] cand_idx;
  logic [3:0] cnt_next;

  assign frame_start = (x == 10'd0) && (y == 10'd0);
  assign frame_end   = (x == X_LAST) && (y == Y_LAST);

  // Candidate extraction from the round's scratch bits
  always_comb begin
    cand_idx = 2'd0;
    if (scratch[0])      cand_idx = 2'd0;
    else if (scratch[1]) cand_idx = 2'd1;
    else if (scratch[2]) cand_idx = 2'd2;
    else if (scratch[3]) cand_idx = 2'd3;
`ifdef REGION_PRIORITY_EN
    cand_valid = |scratch;
`else
    cand_valid = (scratch != 4'd0) && ((scratch & (scratch - 4'd1)) == 4'd0);
`endif
    cnt_next = (cand_idx == prev_cand) ?
               ((stab_cnt == 4'd15) ? 4'd15 : stab_cnt + 4'd1) : 4'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      region      <= 2'd0;
      reg_min     <= 10'd0;
      reg_max     <= 10'(QUARTER);
      scratch     <= 4'd0;
      detect_mask <= 4'd0;
      stab_cnt    <= 4'd0;
      prev_cand   <= 2'd0;
      sel_region  <= 2'd0;
      sel_valid   <= 1'b0;
      sel_pulse   <= 1'b0;
    end else begin
      state       <= state_n;
      region      <= region_n;
      reg_min     <= reg_min_n;
      reg_max     <= reg_max_n;
      scratch     <= scratch_n;
      detect_mask <= detect_mask_n;
      stab_cnt    <= stab_cnt_n;
      prev_cand   <= prev_cand_n;
      sel_region  <= sel_region_n;
      sel_valid   <= sel_valid_n;
      sel_pulse   <= sel_pulse_n;
    end
  end

  always_comb begin
    state_n       = state;
    region_n      = region;
    scratch_n     = scratch;
    detect_mask_n = detect_mask;
    stab_cnt_n    = stab_cnt;
    prev_cand_n   = prev_cand;
    sel_region_n  = sel_region;
    sel_valid_n   = sel_valid;
    sel_pulse_n   = 1'b0;

    case (state)
      IDLE: begin
        if (frame_start) state_n = SCAN;
      end
      SCAN: begin
        // A fresh frame start restarts the scan of the same band
        if (frame_start)    state_n = SCAN;
        else if (frame_end) state_n = LATCH;
      end
      LATCH: begin
        scratch_n[region] = regiao_detectada;
        if (region == 2'd3) begin
          state_n = EVAL;
        end else begin
          region_n = region + 2'd1;
          state_n  = IDLE;
        end
      end
      EVAL: begin
        detect_mask_n = scratch;
        scratch_n     = 4'd0;
        region_n      = 2'd0;
        state_n       = IDLE;
        if (cand_valid) begin
          stab_cnt_n  = cnt_next;
          prev_cand_n = cand_idx;
          // Selection holds only while the candidate has been stable long enough
          if (cnt_next >= STABLE) begin
            sel_valid_n  = 1'b1;
            sel_region_n = cand_idx;
            sel_pulse_n  = !sel_valid || (sel_region != cand_idx);
          end else begin
            sel_valid_n = 1'b0;
          end
        end else begin
          stab_cnt_n  = 4'd0;
          sel_valid_n = 1'b0;
        end
      end
      default: state_n = IDLE;
    endcase

    reg_min_n = 10'(QUARTER * 32'(region_n));
    reg_max_n = 10'(QUARTER * (32'(region_n) + 32'd1));
  end

endmodule
